// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM state encoding and
// the 1-bit ownership tags stored in the in-order response FIFO.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK_I = 2'd1,
        ARB_LOCK_D = 2'd2
    } arb_state_t;

    localparam logic TAG_INST = 1'b0;
    localparam logic TAG_DATA = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_tag_fifo.sv
// arb_tag_fifo: 1-bit wide, DEPTH-deep FIFO recording which master owns
// each accepted-but-unanswered memory transaction. Pointers wrap modulo
// DEPTH so non-power-of-two depths work. Caller never pushes when full
// nor pops when empty.
module arb_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_tag,
    input  logic             pop,
    output logic             head_tag,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    // Pointer and occupancy tracking; push and pop in one cycle keep count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push)
                r_wr_ptr <= next_ptr(r_wr_ptr);
            if (pop)
                r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Tag storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push)
            r_mem[r_wr_ptr] <= push_tag;
    end

    assign head_tag = r_mem[r_rd_ptr];
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like port between the instruction
// fetch master and the data master. Accepted transactions are tagged in
// an in-order FIFO so each mem_data_ok is routed back to its owner.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants between masters in
// IDLE instead of fixed data-over-inst priority.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        arb_err
);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic             w_gnt_inst;
    logic             w_gnt_data;
    logic             w_pick_data;
    logic             w_has_credit;
    logic             w_hs;
    logic             w_push;
    logic             w_pop;
    logic             w_head_tag;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_count;
    logic             r_arb_err;

    // Credit is judged on the registered count only, so a pop in the same
    // cycle does not free a slot until the following cycle.
    assign w_has_credit = (w_count < CNT_W'(MAX_OUTST));

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_data;

    // Round-robin pointer: after each handshake favour the other master.
    always_ff @(posedge clk) begin
        if (reset)
            r_rr_data <= 1'b1;
        else if (w_hs)
            r_rr_data <= ~w_gnt_data;
    end

    assign w_pick_data = data_req & (~inst_req | r_rr_data);
`else
    assign w_pick_data = data_req;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ARB_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next state: an unaccepted grant locks the port to its owner.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_gnt_data && !mem_addr_ok)
                    w_next_state = ARB_LOCK_D;
                else if (w_gnt_inst && !mem_addr_ok)
                    w_next_state = ARB_LOCK_I;
            end
            ARB_LOCK_I, ARB_LOCK_D: begin
                if (w_hs)
                    w_next_state = ARB_IDLE;
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // Grant selection and shared-port mux driven from the granted master.
    always_comb begin
        w_gnt_inst = 1'b0;
        w_gnt_data = 1'b0;
        if (!reset) begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_has_credit) begin
                        if (w_pick_data)
                            w_gnt_data = 1'b1;
                        else if (inst_req)
                            w_gnt_inst = 1'b1;
                    end
                end
                ARB_LOCK_I: w_gnt_inst = inst_req;
                ARB_LOCK_D: w_gnt_data = data_req;
                default: ;
            endcase
        end
        mem_req   = w_gnt_inst | w_gnt_data;
        mem_wr    = w_gnt_data & data_wr;
        mem_wstrb = (w_gnt_data && data_wr) ? data_wstrb : 4'h0;
        mem_wdata = (w_gnt_data && data_wr) ? data_wdata : 32'h0;
        mem_addr  = w_gnt_data ? data_addr : (w_gnt_inst ? inst_addr : 32'h0);
    end

    assign w_hs         = mem_req & mem_addr_ok;
    assign inst_addr_ok = mem_addr_ok & w_gnt_inst;
    assign data_addr_ok = mem_addr_ok & w_gnt_data;
    assign w_push       = w_hs & ~w_fifo_full;
    assign w_pop        = mem_data_ok & ~w_fifo_empty & ~reset;

    arb_tag_fifo #(
        .DEPTH (MAX_OUTST),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .push_tag (w_gnt_data ? TAG_DATA : TAG_INST),
        .pop      (w_pop),
        .head_tag (w_head_tag),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty),
        .count    (w_count)
    );

    // Response routing: the FIFO head names the owner of this response.
    always_comb begin
        inst_data_ok = w_pop & (w_head_tag == TAG_INST);
        data_data_ok = w_pop & (w_head_tag == TAG_DATA);
        inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
        data_rdata   = data_data_ok ? mem_rdata : 32'h0;
    end

    // Sticky error on a response that no transaction is waiting for.
    always_ff @(posedge clk) begin
        if (reset)
            r_arb_err <= 1'b0;
        else if (mem_data_ok && w_fifo_empty)
            r_arb_err <= 1'b1;
    end

    assign arb_err = r_arb_err;

endmodule
